hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/forward_unit.sv | 36 +++
 rtl/hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_hazard_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Purpose : shared encodings for the pipeline hazard unit (action codes,
//           forward selects, counter width) plus small helper functions.
// Latency : n/a (definitions only).  Backpressure: n/a.
package hazard_pkg;

    localparam int CNT_W = 16;

    // Action taken in a cycle; also the encoding of the registered state.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_FREEZE = 2'd3;

    // ALU operand source selects.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // A producer matches a consumer only if it really writes a non-zero
    // register and the consumer really reads that register.
    function automatic logic reg_match(input logic [4:0] prod_rd,
                                       input logic       prod_we,
                                       input logic [4:0] cons_rs,
                                       input logic       cons_use);
        return prod_we && cons_use && (prod_rd != 5'd0) && (prod_rd == cons_rs);
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        if (en && (cnt != {CNT_W{1'b1}}))
            return cnt + 1'b1;
        return cnt;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Purpose : ALU operand forward selection; EX/MEM result beats MEM/WB result.
// Latency : purely combinational.  Backpressure: none.
// Ports   : ex_rs_i/ex_rt_i operands in EX; mem_*/wb_* producer rd and RegWrite;
//           fwd_a_o/fwd_b_o select (00 regfile, 10 EX/MEM, 01 MEM/WB).
// Only instantiated when HAZARD_FORWARD_EN is defined.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwrite_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    function automatic logic [1:0] sel(input logic [4:0] src,
                                       input logic [4:0] mem_rd,
                                       input logic       mem_we,
                                       input logic [4:0] wb_rd,
                                       input logic       wb_we);
        if (reg_match(mem_rd, mem_we, src, 1'b1))
            return FWD_MEM;
        if (reg_match(wb_rd, wb_we, src, 1'b1))
            return FWD_WB;
        return FWD_REG;
    endfunction

    always_comb begin
        fwd_a_o = sel(ex_rs_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
        fwd_b_o = sel(ex_rt_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
    end

endmodule

// File: rtl/hazard_unit.sv
// Purpose : pipeline hazard control: freeze > flush > stall > run, operand
//           forwarding, registered last-action state and saturating counters.
// Latency : control outputs combinational; state/counters update on next edge.
// Backpressure: mem_busy freezes every pipeline register; load-use/RAW stalls
//           hold PC and IF/ID and inject a bubble into ID/EX.
// Ports   : ID/EX/MEM/WB register fields and write flags in; pipeline write
//           enables, bubble clears, fwd selects, state and counters out.
// Config  : HAZARD_FORWARD_EN enables forwarding (stall only on load-use);
//           undefined -> no forwarding, stall on any EX/MEM RAW dependency.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_reset,
    output logic             id_ex_reset,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    logic             hazard;
    logic [1:0]       act;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

`ifdef HAZARD_FORWARD_EN
    // With forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        hazard = ex_memread &&
                 (reg_match(ex_rd, ex_regwrite, id_rs, id_use_rs) ||
                  reg_match(ex_rd, ex_regwrite, id_rt, id_use_rt));
    end

    forward_unit u_forward_unit (
        .ex_rs_i        (ex_rs),
        .ex_rt_i        (ex_rt),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );
`else
    // No bypass: any pending write in EX or MEM must drain first. WB needs
    // no stall because the register file writes before it is read.
    always_comb begin
        hazard = reg_match(ex_rd,  ex_regwrite,  id_rs, id_use_rs) ||
                 reg_match(ex_rd,  ex_regwrite,  id_rt, id_use_rt) ||
                 reg_match(mem_rd, mem_regwrite, id_rs, id_use_rs) ||
                 reg_match(mem_rd, mem_regwrite, id_rt, id_use_rt);
    end

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    // Fields only consumed by the forwarding build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite, ex_memread};
`endif

    always_comb begin
        if (mem_busy)
            act = ST_FREEZE;
        else if (ex_branch_taken)
            act = ST_FLUSH;
        else if (hazard)
            act = ST_STALL;
        else
            act = ST_RUN;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_reset  = 1'b0;
        id_ex_reset  = 1'b0;
        case (act)
            ST_FREEZE: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
            end
            ST_FLUSH: begin
                if_id_reset = 1'b1;
                id_ex_reset = 1'b1;
            end
            ST_STALL: begin
                // Hold PC and IF/ID; the ID/EX clear is the bubble.
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_reset = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = act;
        stall_cnt_d  = sat_inc(stall_cnt_q,  act == ST_STALL);
        flush_cnt_d  = sat_inc(flush_cnt_q,  act == ST_FLUSH);
        freeze_cnt_d = sat_inc(freeze_cnt_q, act == ST_FREEZE);
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
            freeze_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign state      = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Purpose : directed self-checking bench for hazard_unit.
// Latency : checks combinational outputs #1 after driving, registered ones #1
//           after the rising edge.  Backpressure: n/a.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic        mem_regwrite, wb_regwrite, ex_branch_taken, mem_busy, cnt_clr;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic        if_id_reset, id_ex_reset;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id_reset, id_ex_reset}
    localparam logic [6:0] CTL_RUN    = 7'b11111_00;
    localparam logic [6:0] CTL_STALL  = 7'b00111_01;
    localparam logic [6:0] CTL_FLUSH  = 7'b11111_11;
    localparam logic [6:0] CTL_FREEZE = 7'b00000_00;

    logic [6:0] ctl;
    assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  if_id_reset, id_ex_reset};

    always #5 clock = ~clock;

    hazard_unit dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_reset(if_id_reset), .id_ex_reset(id_ex_reset),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        reset = 1'b0; cnt_clr = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_use();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    initial begin
        idle();
        // Reset overrides both the flush action and cnt_clr; comb outputs still live.
        reset = 1'b1; cnt_clr = 1'b1; ex_branch_taken = 1'b1;
        #1;
        check("reset_comb_flush", ctl, CTL_FLUSH);
        step();
        step();
        check("reset_state", state, ST_RUN);
        check("reset_flush_cnt", flush_cnt, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_freeze_cnt", freeze_cnt, 0);

        idle();
        #1;
        check("run_ctl", ctl, CTL_RUN);
        check("run_fwd", {fwd_a, fwd_b}, 4'b0000);

        // Load-use stall.
        load_use();
        #1;
        check("loaduse_ctl", ctl, CTL_STALL);
        step();
        check("loaduse_state", state, ST_STALL);
        check("loaduse_stall_cnt", stall_cnt, 1);

        // Same fields, but the ID instruction does not read rs.
        id_use_rs = 1'b0;
        #1;
        check("nouse_ctl", ctl, CTL_RUN);

        // r0 never stalls.
        idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1;
        check("r0_ctl", ctl, CTL_RUN);
        step();
        check("r0_state", state, ST_RUN);
        check("r0_stall_cnt", stall_cnt, 1);

        // ALU producer in EX, consumer on rt.
        idle();
        ex_regwrite = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
        #1;
`ifdef HAZARD_FORWARD_EN
        check("ex_raw_ctl", ctl, CTL_RUN);
`else
        check("ex_raw_ctl", ctl, CTL_STALL);
`endif

        // Both MEM and WB write r3, EX reads r3 on rs and rt.
        idle();
        ex_rs = 5'd3; ex_rt = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1;
        wb_rd = 5'd3; wb_regwrite = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
        #1;
`ifdef HAZARD_FORWARD_EN
        check("fwd_mem_a", fwd_a, 2'b10);
        check("fwd_mem_b", fwd_b, 2'b10);
        check("fwd_mem_ctl", ctl, CTL_RUN);
`else
        check("fwd_mem_a", fwd_a, 2'b00);
        check("fwd_mem_b", fwd_b, 2'b00);
        check("fwd_mem_ctl", ctl, CTL_STALL);
`endif
        // Only WB writes r3 now.
        mem_regwrite = 1'b0;
        #1;
`ifdef HAZARD_FORWARD_EN
        check("fwd_wb_a", fwd_a, 2'b01);
`else
        check("fwd_wb_a", fwd_a, 2'b00);
`endif
        check("fwd_wb_ctl", ctl, CTL_RUN);

        // Branch and load-use together: flush wins, stall not counted.
        idle();
        load_use();
        ex_branch_taken = 1'b1;
        #1;
        check("brhaz_ctl", ctl, CTL_FLUSH);
        step();
        check("brhaz_state", state, ST_FLUSH);
        check("brhaz_flush_cnt", flush_cnt, 1);
        check("brhaz_stall_cnt", stall_cnt, 1);

        // Clear counters; state still tracks the action.
        idle();
        cnt_clr = 1'b1;
        load_use();
        step();
        check("clr_state", state, ST_STALL);
        check("clr_stall_cnt", stall_cnt, 0);
        check("clr_flush_cnt", flush_cnt, 0);

        // Three frozen cycles with a pending branch and a hazard.
        idle();
        load_use();
        ex_branch_taken = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("freeze_ctl_%0d", i), ctl, CTL_FREEZE);
            step();
        end
        check("freeze_state", state, ST_FREEZE);
        check("freeze_cnt", freeze_cnt, 3);
        check("freeze_stall_cnt", stall_cnt, 0);
        mem_busy = 1'b0;
        #1;
        check("unfreeze_ctl", ctl, CTL_FLUSH);
        step();
        check("unfreeze_state", state, ST_FLUSH);
        check("unfreeze_flush_cnt", flush_cnt, 1);

        // Saturation: 65535 flushes total, then one more.
        idle();
        ex_branch_taken = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        check("sat_reach", flush_cnt, 16'hFFFF);
        step();
        check("sat_hold", flush_cnt, 16'hFFFF);
        check("sat_freeze_cnt", freeze_cnt, 3);
        cnt_clr = 1'b1;
        step();
        check("sat_clr", flush_cnt, 0);
        check("sat_clr_state", state, ST_FLUSH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
